fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter, sequences it, and interfaces to instruction memory with a req/ack handshake. It redirects the PC on taken branches, discards in-flight fetches made stale by a redirect, and holds fetched instructions in a single output slot while decode is stalled. It sits between the instruction memory and the decode stage of the RISC core and replaces ad-hoc PC select/increment logic.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC core front end.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StDrain
    } fetchState_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues req/ack fetches to instruction memory,
// redirects on taken branches and holds one fetched instruction for decode.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_INC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr
);

    fetchState_t       stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic [ADDR_W-1:0] staleAddrQ, staleAddrD;
    logic              ifValidQ, ifValidD;
    logic [ADDR_W-1:0] ifPcQ, ifPcD;
    logic [31:0]       ifInstrQ, ifInstrD;
    logic              slotFree;

    assign slotFree  = !ifValidQ || !stall;
    // A draining request must complete regardless of decode back-pressure.
    assign imem_req  = ((stateQ == StReq) && slotFree) || (stateQ == StDrain);
    assign imem_addr = (stateQ == StDrain) ? staleAddrQ : pcQ;

    assign if_valid = ifValidQ;
    assign if_pc    = ifPcQ;
    assign if_instr = ifInstrQ;

    always_comb begin
        stateD     = stateQ;
        pcD        = pcQ;
        staleAddrD = staleAddrQ;
        ifValidD   = ifValidQ;
        ifPcD      = ifPcQ;
        ifInstrD   = ifInstrQ;

        if (br_valid) begin
            pcD      = br_target;
            ifValidD = 1'b0;
            // An unacknowledged request cannot be withdrawn; finish it on the old address.
            if ((stateQ == StReq) && imem_req && !imem_ack) begin
                staleAddrD = pcQ;
                stateD     = StDrain;
            end else if ((stateQ == StDrain) && !imem_ack) begin
                stateD = StDrain;
            end else begin
                stateD = StReq;
            end
        end else begin
            if (ifValidQ && !stall) begin
                ifValidD = 1'b0;
            end
            unique case (stateQ)
                StBoot: begin
                    stateD = StReq;
                end
                StReq: begin
                    if (imem_req && imem_ack) begin
                        ifValidD = 1'b1;
                        ifPcD    = pcQ;
                        ifInstrD = imem_rdata;
                        pcD      = pcQ + PC_INC;
                    end
                end
                StDrain: begin
                    if (imem_ack) begin
                        stateD = StReq;
                    end
                end
                default: begin
                    stateD = StBoot;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StBoot;
            pcQ        <= RESET_PC;
            staleAddrQ <= '0;
            ifValidQ   <= 1'b0;
            ifPcQ      <= '0;
            ifInstrQ   <= '0;
        end else begin
            stateQ     <= stateD;
            pcQ        <= pcD;
            staleAddrQ <= staleAddrD;
            ifValidQ   <= ifValidD;
            ifPcQ      <= ifPcD;
            ifInstrQ   <= ifInstrD;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed sequences push expected deliveries,
// a negedge monitor pops them whenever decode consumes the output slot.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    int unsigned latency = 0;
    int unsigned waitCnt = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .stall      (stall),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: acks once a request has been held for `latency` cycles.
    assign imem_ack   = imem_req && (waitCnt == latency);
    assign imem_rdata = instrOf(imem_addr);
    always @(posedge clk) waitCnt <= (imem_req && !imem_ack) ? waitCnt + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = instrOf(pc);
        expQ.push_back(e);
    endtask

    task automatic pushRange(input int unsigned lo, input int unsigned hi);
        for (int unsigned i = lo; i <= hi; i++) push(i);
    endtask

    // Leaves the bench in the first cycle after reset release (FSM in BOOT).
    task automatic startTest(input int unsigned lat);
        reset     = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        stall     = 1'b0;
        latency   = lat;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic endTest(input string name);
        reset = 1'b1;
        cyc(1);
        #1;
        chk({name, " reset req"}, {31'b0, imem_req}, 32'd0);
        chk({name, " reset if_valid"}, {31'b0, if_valid}, 32'd0);
        chk({name, " reset addr"}, imem_addr, 32'd0);
        chk({name, " queue drained"}, expQ.size(), 32'd0);
        expQ.delete();
    endtask

    initial begin
        reset     = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        stall     = 1'b0;

        fork
            begin : monitor
                logic        prevOut   = 1'b0;
                logic        prevReset = 1'b1;
                logic [31:0] prevAddr  = '0;
                exp_t        e;
                forever begin
                    @(negedge clk);
                    if (!reset && if_valid && !stall) begin
                        if (expQ.size() == 0) begin
                            nChecks++;
                            nFails++;
                            $display("FAIL unexpected delivery: got pc %h, expected none", if_pc);
                        end else begin
                            e = expQ.pop_front();
                            chk("delivered pc", if_pc, e.pc);
                            chk("delivered instr", if_instr, e.instr);
                        end
                    end
                    if (prevOut && !prevReset) begin
                        chk("outstanding req held", {31'b0, imem_req}, 32'd1);
                        chk("outstanding addr held", imem_addr, prevAddr);
                    end
                    prevOut   = imem_req && !imem_ack;
                    prevAddr  = imem_addr;
                    prevReset = reset;
                end
            end
        join_none

        // Zero-wait streaming.
        startTest(0);
        #1;
        chk("boot req", {31'b0, imem_req}, 32'd0);
        chk("boot addr", imem_addr, 32'd0);
        chk("boot if_valid", {31'b0, if_valid}, 32'd0);
        chk("boot if_pc", if_pc, 32'd0);
        chk("boot if_instr", if_instr, 32'd0);
        pushRange(0, 3);
        cyc(1);
        #1;
        chk("first req", {31'b0, imem_req}, 32'd1);
        chk("first addr", imem_addr, 32'd0);
        chk("first if_valid low", {31'b0, if_valid}, 32'd0);
        cyc(1);
        #1;
        chk("first if_valid", {31'b0, if_valid}, 32'd1);
        chk("first if_pc", if_pc, 32'd0);
        cyc(4);
        endTest("stream");

        // Stall holds the slot at pc 5.
        startTest(0);
        pushRange(0, 6);
        cyc(7);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall req", {31'b0, imem_req}, 32'd0);
            chk("stall if_valid", {31'b0, if_valid}, 32'd1);
            chk("stall if_pc", if_pc, 32'd5);
            chk("stall if_instr", if_instr, instrOf(32'd5));
            cyc(1);
        end
        stall = 1'b0;
        #1;
        chk("unstall req", {31'b0, imem_req}, 32'd1);
        chk("unstall addr", imem_addr, 32'd6);
        cyc(2);
        endTest("stall");

        // Redirect while the fetch of 7 is outstanding (latency 3).
        startTest(0);
        pushRange(0, 6);
        push(32'h40);
        cyc(8);
        latency = 3;
        #1;
        chk("drain issue addr", imem_addr, 32'd7);
        cyc(1);
        br_valid  = 1'b1;
        br_target = 32'h40;
        #1;
        chk("drain br addr", imem_addr, 32'd7);
        cyc(1);
        br_valid = 1'b0;
        #1;
        chk("drain req", {31'b0, imem_req}, 32'd1);
        chk("drain addr", imem_addr, 32'd7);
        chk("drain if_valid", {31'b0, if_valid}, 32'd0);
        cyc(1);
        #1;
        chk("drain ack addr", imem_addr, 32'd7);
        cyc(1);
        #1;
        chk("post-drain req", {31'b0, imem_req}, 32'd1);
        chk("post-drain addr", imem_addr, 32'h40);
        chk("post-drain if_valid", {31'b0, if_valid}, 32'd0);
        cyc(4);
        #1;
        chk("target if_valid", {31'b0, if_valid}, 32'd1);
        chk("target if_pc", if_pc, 32'h40);
        cyc(1);
        endTest("drain");

        // Redirect coinciding with the ack for 9.
        startTest(0);
        pushRange(0, 8);
        push(32'h20);
        push(32'h21);
        cyc(10);
        br_valid  = 1'b1;
        br_target = 32'h20;
        #1;
        chk("br-ack addr", imem_addr, 32'd9);
        cyc(1);
        br_valid = 1'b0;
        #1;
        chk("br-ack if_valid", {31'b0, if_valid}, 32'd0);
        chk("br-ack next addr", imem_addr, 32'h20);
        cyc(3);
        endTest("brack");

        // PC wraps from all-ones to zero.
        startTest(0);
        br_valid  = 1'b1;
        br_target = 32'hFFFF_FFFF;
        push(32'hFFFF_FFFF);
        push(32'd0);
        push(32'd1);
        cyc(1);
        br_valid = 1'b0;
        #1;
        chk("wrap top addr", imem_addr, 32'hFFFF_FFFF);
        cyc(1);
        #1;
        chk("wrap next addr", imem_addr, 32'd0);
        chk("wrap if_pc", if_pc, 32'hFFFF_FFFF);
        cyc(3);
        endTest("wrap");

        // Reset during the ack cycle of an outstanding request.
        startTest(1);
        cyc(2);
        reset = 1'b1;
        #1;
        chk("mid-reset req", {31'b0, imem_req}, 32'd1);
        chk("mid-reset addr", imem_addr, 32'd0);
        cyc(1);
        #1;
        chk("after reset req", {31'b0, imem_req}, 32'd0);
        chk("after reset if_valid", {31'b0, if_valid}, 32'd0);
        chk("after reset addr", imem_addr, 32'd0);
        reset = 1'b0;
        push(32'd0);
        cyc(3);
        #1;
        chk("restart if_pc", if_pc, 32'd0);
        cyc(1);
        endTest("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
